// File: rtl/act_vec_sched.sv
// Streams an N-element float vector through one shared start/done activation unit; done at 1+N*(L+1) cycles.
// Define ACT_TIMEOUT_EN to replace a missing act_done with a quiet NaN after TIMEOUT wait cycles and raise error.
module act_vec_sched #(
  parameter int S       = 32,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [S*N-1:0] x,
  output logic [S*N-1:0] y,
  output logic           busy,
  output logic           done,
  output logic           act_start,
  output logic [S-1:0]   act_x,
  input  logic [S-1:0]   act_y,
  input  logic           act_done,
  output logic           error
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]     state, state_nxt;
  logic [IW-1:0]  idx, idx_inc;
  logic [S*N-1:0] xbuf, ybuf, ybuf_nxt;
  logic [S-1:0]   elem_val;
  logic           elem_done, tmo, last;

`ifdef ACT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = (S == 64) ? 11 : (S == 16) ? 5 : 8;
  localparam logic [S-1:0] ONE  = {{(S-1){1'b0}}, 1'b1};
  // sign 0, exponent all ones, mantissa MSB set
  localparam logic [S-1:0] QNAN = (ONE << (S-1)) - (ONE << (S-2-EW));

  logic [CW-1:0] wcnt;

  assign tmo      = (state == ST_WAIT) && !act_done && (wcnt == CW'(TIMEOUT - 1));
  assign elem_val = act_done ? act_y : QNAN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      error <= 1'b0;
    end else begin
      if (state == ST_ISSUE)
        wcnt <= '0;
      else if (state == ST_WAIT)
        wcnt <= wcnt + CW'(1);
      if (state == ST_IDLE && start)
        error <= 1'b0;
      else if (tmo)
        error <= 1'b1;
    end
  end
`else
  assign tmo      = 1'b0;
  assign elem_val = act_y;
  assign error    = 1'b0;
`endif

  assign elem_done = (state == ST_WAIT) && (act_done || tmo);
  assign last      = (idx == IW'(N - 1));
  assign idx_inc   = last ? idx : idx + IW'(1);

  always_comb begin
    ybuf_nxt = ybuf;
    ybuf_nxt[S*int'(idx) +: S] = elem_val;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (elem_done) state_nxt = last ? ST_FIN : ST_ISSUE;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // status outputs are flops decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      act_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_FIN);
      act_start <= (state_nxt == ST_ISSUE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      xbuf  <= '0;
      ybuf  <= '0;
      y     <= '0;
      act_x <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            xbuf  <= x;
            idx   <= '0;
            ybuf  <= '0;
            act_x <= x[S-1:0];
          end
        end
        ST_WAIT: begin
          if (elem_done) begin
            ybuf <= ybuf_nxt;
            // whole vector lands on the edge into FIN, so y is valid with done
            if (last) begin
              y <= ybuf_nxt;
            end else begin
              idx   <= idx_inc;
              act_x <= xbuf[S*int'(idx_inc) +: S];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_act_vec_sched.sv
// Randomized bench for act_vec_sched with a stub activation unit (|x|, programmable latency) and a vector-level model.
module tb_act_vec_sched;
  localparam int S     = 32;
  localparam int N     = 4;
  localparam int TMO   = 8;
  localparam int NEVER = 1000;
  localparam logic [S-1:0] QNAN = 32'h7fc00000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [S*N-1:0] x = '0;
  logic [S*N-1:0] y;
  logic           busy, done, act_start, error;
  logic [S-1:0]   act_x;
  logic [S-1:0]   act_y = '0;
  logic           act_done = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int           lat [N];
  int           n_issued = 0;
  logic [S-1:0] seen_q [$];
  bit           stray_iss = 1'b0;
  bit           stray_idle = 1'b0;

  act_vec_sched #(.S(S), .N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .busy(busy), .done(done),
    .act_start(act_start), .act_x(act_x), .act_y(act_y), .act_done(act_done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [S*N-1:0] obs, input logic [S*N-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // activation stub: answers |act_x| lat[k] cycles after the k-th act_start
  bit           pend = 1'b0;
  int           rem = 0;
  logic [S-1:0] pval = '0;
  always begin
    @(posedge clk);
    #2;
    act_done = 1'b0;
    act_y    = '0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        rem--;
        if (rem == 0) begin
          act_done = 1'b1;
          act_y    = {1'b0, pval[S-2:0]};
          pend     = 1'b0;
        end
      end
      if (act_start) begin
        seen_q.push_back(act_x);
        pval = act_x;
        rem  = (n_issued < N) ? lat[n_issued] : 1;
        pend = 1'b1;
        n_issued++;
        if (stray_iss) begin
          act_done = 1'b1;
          act_y    = 32'hdeadbeef;
        end
      end
      if (!busy && stray_idle) begin
        act_done = 1'b1;
        act_y    = 32'hbad0bad0;
      end
    end
  end

  task automatic run_vec(input logic [S*N-1:0] xv, input bit ign, input bit s_iss,
                         input bit s_idle, input string tag);
    logic [S*N-1:0] expy;
    logic [S-1:0]   elem;
    int             exp_cyc, t0, rel, eff;
    bit             got, exp_err;
    exp_cyc = 1;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      elem = xv[S*i +: S];
      eff  = lat[i];
      expy[S*i +: S] = {1'b0, elem[S-2:0]};
`ifdef ACT_TIMEOUT_EN
      if (eff > TMO) begin
        eff = TMO;
        exp_err = 1'b1;
        expy[S*i +: S] = QNAN;
      end
`endif
      exp_cyc += eff + 1;
    end

    n_issued = 0;
    seen_q.delete();
    stray_iss = s_iss;
    if (s_idle) begin
      stray_idle = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      stray_idle = 1'b0;
    end
    start = 1'b1;
    x     = xv;
    t0    = cyc;
    got   = 1'b0;
    rel   = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk);
      #1;
      rel   = cyc - t0;
      start = ign && (rel == 3 || rel == 9);
      if (start) x = ~xv;
      if (rel == 1) begin
        check_val({tag, "_busy_c1"}, busy, 1);
        check_val({tag, "_err_c1"}, error, 0);
      end
      if (done) got = 1'b1;
    end
    start     = 1'b0;
    stray_iss = 1'b0;
    check_val({tag, "_done_seen"}, got, 1);
    if (got) begin
      check_val({tag, "_done_cycle"}, rel, exp_cyc);
      check_val({tag, "_y"}, y, expy);
      check_val({tag, "_busy_at_done"}, busy, 1);
      check_val({tag, "_error"}, error, exp_err);
      check_val({tag, "_pulses"}, n_issued, N);
      for (int i = 0; i < N; i++)
        check_val({tag, $sformatf("_order%0d", i)}, (i < seen_q.size()) ? seen_q[i] : 'x, xv[S*i +: S]);
      @(posedge clk);
      #1;
      check_val({tag, "_done_pulse"}, done, 0);
      check_val({tag, "_busy_after"}, busy, 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_y", y, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_act_start", act_start, 0);
    check_val("rst_act_x", act_x, 0);
    check_val("rst_error", error, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat = '{3, 3, 3, 3};
    run_vec(128'hc0800000_40000000_bf800000_3f800000, 0, 0, 0, "single");
    check_val("single_y_const", y, 128'h40800000_40000000_3f800000_3f800000);

    lat = '{1, 1, 1, 1};
    run_vec({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, "order");

    lat = '{3, 3, 3, 3};
    run_vec({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, "ignstart");

    lat = '{1, 5, 2, 7};
    run_vec({$urandom, $urandom, $urandom, $urandom}, 0, 1, 1, "varlat");

    // reset during WAIT of element 2
    lat = '{4, 4, 4, 4};
    n_issued = 0;
    seen_q.delete();
    start = 1'b1;
    x = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 100 && n_issued < 3; k++) begin @(posedge clk); #1; end
    check_val("midrst_reached", n_issued, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_act_start", act_start, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_y", y, 0);
    check_val("midrst_act_x", act_x, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lat = '{2, 2, 2, 2};
    run_vec({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, "fresh");

`ifdef ACT_TIMEOUT_EN
    lat = '{2, NEVER, 3, 1};
    run_vec({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, "timeout");
    lat = '{1, 2, 1, 2};
    run_vec({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, "after_tmo");
`endif

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 6);
      run_vec({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
